frv_dmem_responder: RTL

Data-memory responder for the core's `dmem_*` bus. It terminates the load/store unit's requests with a word-organised, byte-strobed SRAM model. It inserts a configurable number of stall cycles per transaction and flags out-of-range accesses with a bus error. It is used in the core testbench and on FPGA builds as the data memory attached directly to the core.

---
 rtl/frv_dmem_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/frv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : frv_dmem_responder
// Description : Word-organised, byte-strobed data memory for the dmem_* bus,
//               with per-transaction stall insertion and out-of-range errors.
//               Optional random stall length: define FRV_DMEM_RAND_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module frv_dmem_responder #(
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          SIZE_WORDS  = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        dmem_cen,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_stall,
    output logic        dmem_error
);

    localparam int          c_IDX_W = $clog2(SIZE_WORDS);
    localparam logic [32:0] c_LIMIT = 33'(SIZE_WORDS) << 2;
`ifdef FRV_DMEM_RAND_STALL_EN
    localparam bit          c_RAND  = 1'b1;
`else
    localparam bit          c_RAND  = 1'b0;
`endif
    localparam bit          c_ASYNC_RD = c_RAND || (WAIT_CYCLES == 0);
    localparam bit          c_SYNC_RD  = (WAIT_CYCLES > 0);

    localparam logic [0:0]  S_IDLE = 1'b0;
    localparam logic [0:0]  S_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [3:0]         r_cnt;
    logic [31:0]        r_addr;
    logic               r_wen;
    logic [3:0]         r_strb;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rd_q;
    logic [31:0]        r_mem [SIZE_WORDS];

    logic [3:0]         w_wait;
    logic               w_idle;
    logic [31:0]        w_acc_addr;
    logic               w_acc_wen;
    logic [3:0]         w_acc_strb;
    logic [31:0]        w_acc_wdata;
    logic [32:0]        w_offset;
    logic               w_in_range;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_complete;
    logic               w_do_write;
    logic               w_rd_en;
    logic [31:0]        w_async_word;

    // ------------------------------------------------------------------
    // Wait-count source
    // ------------------------------------------------------------------
`ifdef FRV_DMEM_RAND_STALL_EN
    localparam logic [4:0] c_MOD = 5'(WAIT_CYCLES + 1);
    logic [15:0] r_lfsr;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_wait = 4'({1'b0, r_lfsr[3:0]} % c_MOD);
`else
    assign w_wait = 4'(WAIT_CYCLES);
`endif

    // ------------------------------------------------------------------
    // Access selection: live inputs on the accept cycle, captured copy after
    // ------------------------------------------------------------------
    assign w_idle      = (r_state == S_IDLE);
    assign w_acc_addr  = w_idle ? dmem_addr  : r_addr;
    assign w_acc_wen   = w_idle ? dmem_wen   : r_wen;
    assign w_acc_strb  = w_idle ? dmem_strb  : r_strb;
    assign w_acc_wdata = w_idle ? dmem_wdata : r_wdata;

    // 33-bit offset: a borrow flags addr < BASE and nothing wraps at the top
    assign w_offset   = {1'b0, w_acc_addr} - {1'b0, BASE};
    assign w_in_range = !w_offset[32] && (w_offset < c_LIMIT);
    assign w_idx      = w_offset[c_IDX_W+1:2];

    assign w_complete = dmem_cen && (w_idle ? (w_wait == 4'd0) : (r_cnt == 4'd0));
    assign w_do_write = w_complete && w_in_range && w_acc_wen && g_resetn;
    assign w_rd_en    = dmem_cen && (w_idle ? (w_wait == 4'd1) : (r_cnt == 4'd1));

    assign dmem_stall = dmem_cen && !w_complete;
    assign dmem_error = w_complete && !w_in_range;
    assign dmem_rdata = (w_complete && w_in_range && !w_acc_wen)
                      ? (w_idle ? w_async_word : r_rd_q) : 32'h0;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dmem_cen && (w_wait != 4'd0)) begin
                        r_state <= S_BUSY;
                        r_cnt   <= 4'(w_wait - 4'd1);
                    end
                end
                S_BUSY: begin
                    if (!dmem_cen) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt   <= 4'(r_cnt - 4'd1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (w_idle && dmem_cen) begin
            r_addr  <= dmem_addr;
            r_wen   <= dmem_wen;
            r_strb  <= dmem_strb;
            r_wdata <= dmem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    always_ff @(posedge g_clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_strb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    generate
        if (c_SYNC_RD) begin : g_sync_rd
            // Read lands in r_rd_q on the last stall cycle, ready at completion
            always_ff @(posedge g_clk) begin
                if (w_rd_en) begin
                    r_rd_q <= r_mem[w_idx];
                end
            end
        end else begin : g_no_sync_rd
            logic w_unused_rd_en;
            assign w_unused_rd_en = w_rd_en;
            always_ff @(posedge g_clk) begin
                r_rd_q <= 32'h0;
            end
        end
    endgenerate

    generate
        if (c_ASYNC_RD) begin : g_async_rd
            assign w_async_word = r_mem[w_idx];
        end else begin : g_no_async_rd
            assign w_async_word = 32'h0;
        end
    endgenerate

endmodule
`default_nettype wire
